// File: rtl/soc_irq_pkg.sv
// Shared definitions for the interrupt aggregator: register map, FSM states, limits.
package soc_irq_pkg;
  localparam int IRQ_MAX = 16;

  localparam logic [2:0] IRQ_ADDR_PEND    = 3'd0;
  localparam logic [2:0] IRQ_ADDR_ENABLE  = 3'd1;
  localparam logic [2:0] IRQ_ADDR_EDGE    = 3'd2;
  localparam logic [2:0] IRQ_ADDR_ACTIVE  = 3'd3;
  localparam logic [2:0] IRQ_ADDR_HOLDOFF = 3'd4;
  localparam logic [2:0] IRQ_ADDR_ACK     = 3'd5;
  localparam logic [2:0] IRQ_ADDR_RAW     = 3'd6;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    HOLDOFF = 2'd2
  } irq_state_e;
endpackage

// File: rtl/soc_irq_ctrl_if.sv
// Avalon-MM slave bus (16-bit data, 1-cycle registered read) for the interrupt aggregator.
interface soc_irq_ctrl_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/soc_irq_sync.sv
// One interrupt line: SYNC_STAGES-deep synchroniser (0 = bypass) and a registered rising-edge pulse.
module soc_irq_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_irq,
  output logic o_sync,
  output logic o_rise
);
  logic w_sync;
  logic r_dly;
  logic r_rise;

  if (SYNC_STAGES == 0) begin : g_bypass
    assign w_sync = i_irq;
  end else begin : g_chain
    logic [SYNC_STAGES-1:0] r_chain;
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_chain <= '0;
      end else begin
        r_chain[0] <= i_irq;
        for (int k = 1; k < SYNC_STAGES; k++) r_chain[k] <= r_chain[k-1];
      end
    end
    assign w_sync = r_chain[SYNC_STAGES-1];
  end

  // Registering the edge pulse puts edge capture one cycle behind level capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dly  <= 1'b0;
      r_rise <= 1'b0;
    end else begin
      r_dly  <= w_sync;
      r_rise <= w_sync & ~r_dly;
    end
  end

  assign o_sync = w_sync;
  assign o_rise = r_rise;
endmodule

// File: rtl/soc_irq_ctrl.sv
// Interrupt aggregator: per-line level/edge capture, mask, priority encode, and a
// registered irq_out with a post-acknowledge holdoff.
module soc_irq_ctrl
  import soc_irq_pkg::*;
#(
  parameter int NUM_IRQ     = 8,
  parameter int SYNC_STAGES = 2,
  parameter int HOLDOFF_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_in,
  soc_irq_ctrl_if.slave      bus,
  output logic               irq_out
);
  logic [NUM_IRQ-1:0]   w_sync, w_rise, w_w1c, w_act;
  logic [NUM_IRQ-1:0]   r_pend, r_en, r_edge;
  logic [HOLDOFF_W-1:0] r_holdoff, r_cnt;
  logic [15:0]          w_rdata, r_rdata;
  logic [3:0]           w_idx;
  logic                 w_wr, w_ack, w_any, r_irq_out;
  irq_state_e           r_state;

  soc_irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync [NUM_IRQ-1:0] (
    .clk    (clk),
    .reset  (reset),
    .i_irq  (irq_in),
    .o_sync (w_sync),
    .o_rise (w_rise)
  );

  assign w_wr  = bus.chipselect & ~bus.write_n;
  assign w_ack = w_wr && (bus.address == IRQ_ADDR_ACK);
  assign w_w1c = (w_wr && bus.address == IRQ_ADDR_PEND) ? bus.writedata[NUM_IRQ-1:0] : '0;
  assign w_act = r_pend & r_en;
  assign w_any = |w_act;

  // Scan downwards so the lowest active index wins.
  always_comb begin
    w_idx = '0;
    for (int i = NUM_IRQ-1; i >= 0; i--) if (w_act[i]) w_idx = 4'(i);
  end

  always_comb begin
    w_rdata = '0;
    case (bus.address)
      IRQ_ADDR_PEND:    w_rdata[NUM_IRQ-1:0]   = r_pend;
      IRQ_ADDR_ENABLE:  w_rdata[NUM_IRQ-1:0]   = r_en;
      IRQ_ADDR_EDGE:    w_rdata[NUM_IRQ-1:0]   = r_edge;
      IRQ_ADDR_ACTIVE:  if (w_any) w_rdata     = {1'b1, 11'd0, w_idx};
      IRQ_ADDR_HOLDOFF: w_rdata[HOLDOFF_W-1:0] = r_holdoff;
      IRQ_ADDR_RAW:     w_rdata[NUM_IRQ-1:0]   = w_sync;
      default:          w_rdata                = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rdata   <= '0;
      r_pend    <= '0;
      r_en      <= '0;
      r_edge    <= '0;
      r_holdoff <= '0;
    end else begin
      r_rdata <= w_rdata;
      // Edge bits: a new rise beats a same-cycle W1C. Level bits track the input.
      r_pend  <= (r_edge & (w_rise | (r_pend & ~w_w1c))) | (~r_edge & w_sync);
      if (w_wr) begin
        case (bus.address)
          IRQ_ADDR_ENABLE:  r_en      <= bus.writedata[NUM_IRQ-1:0];
          IRQ_ADDR_EDGE:    r_edge    <= bus.writedata[NUM_IRQ-1:0];
          IRQ_ADDR_HOLDOFF: r_holdoff <= bus.writedata[HOLDOFF_W-1:0];
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_irq_out <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_any) begin
          r_state   <= ASSERT;
          r_irq_out <= 1'b1;
        end
        ASSERT: if (w_ack) begin
          r_irq_out <= 1'b0;
          if (r_holdoff == '0) r_state <= IDLE;
          else begin
            r_state <= HOLDOFF;
            r_cnt   <= r_holdoff;
          end
        end else if (!w_any) begin
          r_state   <= IDLE;
          r_irq_out <= 1'b0;
        end
        HOLDOFF: begin
          r_cnt <= r_cnt - 1'b1;
          // Last holdoff cycle: fold the IDLE check in so a waiting source re-asserts at once.
          if (r_cnt == HOLDOFF_W'(1)) begin
            r_state   <= w_any ? ASSERT : IDLE;
            r_irq_out <= w_any;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_irq_out <= 1'b0;
        end
      endcase
    end
  end

  assign bus.readdata = r_rdata;
  assign irq_out      = r_irq_out;
endmodule
